// File: rtl/case_lut_pkg.sv
// rtl/case_lut_pkg.sv - shared types, counter width and saturating increment for case_lut_pipe
package case_lut_pkg;

  localparam int CNT_W  = 16;
  localparam int LUT_IW = 8;
  localparam int LUT_OW = 10;

  typedef struct packed {
    logic              en;
    logic [LUT_IW-1:0] key;
    logic [LUT_OW-1:0] val;
  } lut_entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/case_lut_match.sv
// rtl/case_lut_match.sv - combinational first-match priority matcher over the entry array
module case_lut_match
  import case_lut_pkg::*;
#(
  parameter int IW      = 8,
  parameter int OW      = 10,
  parameter int ENTRIES = 34
) (
  input  logic [ENTRIES-1:0]         en,
  input  logic [ENTRIES-1:0][IW-1:0] keys,
  input  logic [ENTRIES-1:0][OW-1:0] vals,
  input  logic [IW-1:0]              index,
  output logic                       hit,
  output logic [OW-1:0]              val
);

  // Scan from the top slot down so the lowest matching slot overrides the rest.
  always_comb begin
    hit = 1'b0;
    val = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (en[i] && (keys[i] == index)) begin
        hit = 1'b1;
        val = vals[i];
      end
    end
  end

endmodule

// File: rtl/case_lut_pipe.sv
// rtl/case_lut_pipe.sv - two-stage registered sparse LUT with hold-on-miss; CASE_LUT_STATS_EN adds hit/miss counters
module case_lut_pipe
  import case_lut_pkg::*;
#(
  parameter int              IW        = 8,
  parameter int              OW        = 10,
  parameter int              ENTRIES   = 34,
  parameter logic [OW-1:0]   RESET_VAL = 'h001
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(ENTRIES)-1:0] cfg_idx,
  input  logic [IW-1:0]              cfg_key,
  input  logic [OW-1:0]              cfg_val,
  input  logic                       cfg_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IW-1:0]              in_index,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OW-1:0]              out_q,
  output logic                       out_hit
`ifdef CASE_LUT_STATS_EN
  ,
  output logic [CNT_W-1:0]           hit_cnt,
  output logic [CNT_W-1:0]           miss_cnt
`endif
);

  localparam int XW = $clog2(ENTRIES);

  logic [ENTRIES-1:0]         tbl_en;
  logic [ENTRIES-1:0][IW-1:0] tbl_key;
  logic [ENTRIES-1:0][OW-1:0] tbl_val;

  logic          cfg_wr_ok;
  logic          m_hit;
  logic [OW-1:0] m_val;
  logic          s1_valid;
  logic          s1_hit;
  logic [OW-1:0] s1_val;
  logic          s1_adv;
  logic          s2_adv;

  assign cfg_wr_ok = cfg_we && ({1'b0, cfg_idx} < (XW + 1)'(ENTRIES));
  assign s2_adv    = !out_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;

  // Table storage; a write lands on the same edge a lookup is captured, so that lookup sees the old table.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_en  <= '0;
      tbl_key <= '0;
      tbl_val <= '0;
    end else if (cfg_wr_ok) begin
      tbl_en[cfg_idx]  <= cfg_en;
      tbl_key[cfg_idx] <= cfg_key;
      tbl_val[cfg_idx] <= cfg_val;
    end
  end

  case_lut_match #(
    .IW      (IW),
    .OW      (OW),
    .ENTRIES (ENTRIES)
  ) u_match (
    .en    (tbl_en),
    .keys  (tbl_key),
    .vals  (tbl_val),
    .index (in_index),
    .hit   (m_hit),
    .val   (m_val)
  );

  // Stage 1: capture the match result of an accepted lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_val   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_hit <= m_hit;
        s1_val <= m_val;
      end
    end
  end

  // Stage 2: output register; a miss keeps the previously presented value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= RESET_VAL;
      out_hit   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_hit <= s1_hit;
        if (s1_hit) begin
          out_q <= s1_val;
        end
      end
    end
  end

`ifdef CASE_LUT_STATS_EN
  // Saturating hit/miss counters, stepped when a result is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_hit) begin
        hit_cnt <= sat_inc(hit_cnt);
      end else begin
        miss_cnt <= sat_inc(miss_cnt);
      end
    end
  end
`endif

endmodule
